// File: rtl/morph_frame_scheduler.sv
// Mode scheduler for the erode/dilate morphology pipeline: applies configs at input frame starts
// and reports per-frame pixel counts seen at the pipeline output.
module morph_frame_scheduler #(
  parameter int unsigned H_ACT = 640,
  parameter int unsigned V_ACT = 480,
  parameter int unsigned PIX_W = 20
) (
  input  logic             clk_i,
  input  logic             a_rst_i,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [1:0]       cfg_mode,
  input  logic [7:0]       cfg_frames,
  input  logic             i_vsyn,
  input  logic             p_vs,
  input  logic             p_en,
  output logic [1:0]       o_mode,
  output logic             o_busy,
  output logic             o_frame_done,
  output logic [PIX_W-1:0] o_pix_cnt,
  output logic             o_err
);

  localparam logic [PIX_W-1:0] FramePix = PIX_W'(H_ACT * V_ACT);
  localparam logic [PIX_W-1:0] PixMax   = '1;

  typedef enum logic [1:0] {StIdle, StPend, StRun} state_e;

  state_e           state_q;
  logic             vs_q, ovs_q, armed_q;
  logic [1:0]       pend_mode_q;
  logic [7:0]       pend_frames_q, rem_q;
  logic [PIX_W-1:0] pcnt_q;

  logic             vs_rise, ovs_rise, accept;
  logic [PIX_W-1:0] pcnt_inc;

  always_comb begin
    vs_rise   = i_vsyn & ~vs_q;
    ovs_rise  = p_vs & ~ovs_q;
    cfg_ready = (state_q != StPend);
    accept    = cfg_valid & cfg_ready;
    o_busy    = (state_q != StIdle);
    // Also the reported value on ovs_rise, so a pixel on the sync cycle lands in the old frame.
    pcnt_inc  = (p_en && (pcnt_q != PixMax)) ? pcnt_q + PIX_W'(1) : pcnt_q;
  end

  always_ff @(posedge clk_i) begin
    if (a_rst_i) begin
      state_q       <= StIdle;
      vs_q          <= 1'b0;
      pend_mode_q   <= 2'd0;
      pend_frames_q <= 8'd0;
      rem_q         <= 8'd0;
      o_mode        <= 2'd0;
    end else begin
      vs_q <= i_vsyn;
      if (accept) begin
        pend_mode_q   <= cfg_mode;
        pend_frames_q <= cfg_frames;
      end
      case (state_q)
        StIdle: begin
          if (accept) state_q <= StPend;
        end
        StPend: begin
          if (vs_rise) begin
            o_mode  <= pend_mode_q;
            rem_q   <= pend_frames_q;
            state_q <= StRun;
          end
        end
        StRun: begin
          // rem_q == 0 means run continuously; the frame-count update happens even with an accept.
          if (vs_rise) begin
            if (rem_q == 8'd1) begin
              o_mode  <= 2'd0;
              state_q <= StIdle;
            end else if (rem_q > 8'd1) begin
              rem_q <= rem_q - 8'd1;
            end
          end
          if (accept) state_q <= StPend;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (a_rst_i) begin
      ovs_q        <= 1'b0;
      armed_q      <= 1'b0;
      pcnt_q       <= '0;
      o_frame_done <= 1'b0;
      o_pix_cnt    <= '0;
      o_err        <= 1'b0;
    end else begin
      ovs_q        <= p_vs;
      o_frame_done <= 1'b0;
      if (ovs_rise) begin
        pcnt_q  <= '0;
        armed_q <= 1'b1;
        // First sync after reset only arms; the partial frame before it is dropped.
        if (armed_q) begin
          o_pix_cnt    <= pcnt_inc;
          o_frame_done <= 1'b1;
          if (pcnt_inc != FramePix) o_err <= 1'b1;
        end
      end else begin
        pcnt_q <= pcnt_inc;
      end
    end
  end

endmodule

// File: tb/tb_morph_frame_scheduler.sv
// Directed frame sequence with randomized pixel spacing and config lengths for
// morph_frame_scheduler, checked against per-frame expected modes and pixel totals.
module tb_morph_frame_scheduler;

  localparam int unsigned H    = 16;
  localparam int unsigned V    = 8;
  localparam int unsigned PW   = 20;
  localparam int          FULL = H * V;

  logic          clk = 1'b0;
  logic          a_rst, cfg_valid, cfg_ready, i_vsyn, p_vs, p_en;
  logic [1:0]    cfg_mode, o_mode;
  logic [7:0]    cfg_frames;
  logic          o_busy, o_frame_done, o_err;
  logic [PW-1:0] o_pix_cnt;

  always #5 clk = ~clk;

  morph_frame_scheduler #(.H_ACT(H), .V_ACT(V), .PIX_W(PW)) dut (
    .clk_i        (clk),
    .a_rst_i      (a_rst),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_mode     (cfg_mode),
    .cfg_frames   (cfg_frames),
    .i_vsyn       (i_vsyn),
    .p_vs         (p_vs),
    .p_en         (p_en),
    .o_mode       (o_mode),
    .o_busy       (o_busy),
    .o_frame_done (o_frame_done),
    .o_pix_cnt    (o_pix_cnt),
    .o_err        (o_err)
  );

  int n_vec = 0;
  int n_err = 0;
  // Reference model of the output monitor: pixels seen since last sync, armed, sticky error.
  int acc   = 0;
  bit armed_m = 1'b0;
  bit err_m   = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      $error("miscompare at %s", tag);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One input/output frame: sync cycle, npix enables with random gaps, two idle cycles.
  // em/eb0 are the mode/busy expected right after the sync edge, eb1 the busy at frame end.
  task automatic frame(input int npix, input bit pen0, input logic [1:0] em, input bit eb0,
                       input bit eb1, input bit cdo, input int cat, input logic [1:0] cm,
                       input logic [7:0] cf);
    int gap;
    int rep;
    i_vsyn = 1'b1;
    p_vs   = 1'b1;
    p_en   = pen0;
    if (cdo && cat < 0) begin
      check("ready_at_vs", cfg_ready, 1);
      cfg_valid = 1'b1; cfg_mode = cm; cfg_frames = cf;
    end
    step();
    cfg_valid = 1'b0;
    if (cdo && cat < 0) check("ready_pend_vs", cfg_ready, 0);
    if (armed_m) begin
      rep = acc + int'(pen0);
      if (rep != FULL) err_m = 1'b1;
      check("frame_done", o_frame_done, 1);
      check("pix_cnt", o_pix_cnt, rep);
      check("err", o_err, err_m);
    end else begin
      check("no_report", o_frame_done, 0);
    end
    armed_m = 1'b1;
    acc     = 0;
    check("mode_start", o_mode, em);
    check("busy_start", o_busy, eb0);
    i_vsyn = 1'b0;
    p_vs   = 1'b0;
    for (int k = 0; k < npix; k++) begin
      gap = $urandom_range(0, 1);
      p_en = 1'b0;
      repeat (gap) step();
      if (cdo && k == cat) begin
        check("ready_req", cfg_ready, 1);
        cfg_valid = 1'b1; cfg_mode = cm; cfg_frames = cf;
      end
      p_en = 1'b1;
      step();
      if (cfg_valid) begin
        cfg_valid = 1'b0;
        check("ready_pend", cfg_ready, 0);
      end
    end
    p_en = 1'b0;
    step();
    step();
    check("mode_end", o_mode, em);
    check("busy_end", o_busy, eb1);
    check("done_idle", o_frame_done, 0);
    acc = npix;
  endtask

  initial begin
    logic [1:0] rm;
    int         rn;
    a_rst = 1'b1; cfg_valid = 1'b0; cfg_mode = 2'd0; cfg_frames = 8'd0;
    i_vsyn = 1'b0; p_vs = 1'b0; p_en = 1'b0;
    repeat (2) step();
    a_rst = 1'b0;

    // Arm the monitor, then reset in the middle of a frame.
    p_vs = 1'b1; step(); p_vs = 1'b0;
    repeat (5) begin p_en = 1'b1; step(); end
    a_rst = 1'b1;
    repeat (2) step();
    check("rst_mode", o_mode, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_frame_done, 0);
    check("rst_cnt", o_pix_cnt, 0);
    check("rst_err", o_err, 0);
    check("rst_ready", cfg_ready, 1);
    a_rst = 1'b0;
    repeat (7) step();
    p_en = 1'b0;
    step();

    // Open for two frames, requested mid-frame from idle.
    frame(FULL, 0, 2'd0, 0, 0, 0, 0, 2'd0, 8'd0);
    frame(FULL, 0, 2'd0, 0, 1, 1, FULL / 2, 2'd3, 8'd2);
    frame(FULL, 0, 2'd3, 1, 1, 0, 0, 2'd0, 8'd0);
    frame(FULL, 0, 2'd3, 1, 1, 0, 0, 2'd0, 8'd0);

    // Random mode and length.
    rm = 2'($urandom_range(1, 3));
    rn = $urandom_range(1, 4);
    frame(FULL, 0, 2'd0, 0, 1, 1, $urandom_range(0, FULL - 1), rm, 8'(rn));
    for (int i = 0; i < rn; i++) frame(FULL, 0, rm, 1, 1, 0, 0, 2'd0, 8'd0);

    // Continuous erode, then dilate requested mid-frame, then one bypass frame to idle.
    frame(FULL, 0, 2'd0, 0, 1, 1, $urandom_range(0, FULL - 1), 2'd1, 8'd0);
    for (int i = 0; i < 5; i++)
      frame(FULL, 0, 2'd1, 1, 1, (i == 4), $urandom_range(0, FULL - 1), 2'd2, 8'd0);
    frame(FULL, 0, 2'd2, 1, 1, 1, $urandom_range(0, FULL - 1), 2'd0, 8'd1);
    frame(FULL, 0, 2'd0, 1, 1, 0, 0, 2'd0, 8'd0);
    frame(FULL, 0, 2'd0, 0, 0, 0, 0, 2'd0, 8'd0);

    // Request coinciding with the sync edge from idle waits one more frame.
    frame(FULL, 0, 2'd0, 1, 1, 1, -1, 2'd2, 8'd1);
    frame(FULL, 0, 2'd2, 1, 1, 0, 0, 2'd0, 8'd0);

    // Monitor: short frame, pixel on the sync cycle, empty frame, recovery with sticky error.
    frame(FULL - 1, 0, 2'd0, 0, 0, 0, 0, 2'd0, 8'd0);
    frame(FULL - 1, 0, 2'd0, 0, 0, 0, 0, 2'd0, 8'd0);
    frame(FULL, 1, 2'd0, 0, 0, 0, 0, 2'd0, 8'd0);
    frame(0, 0, 2'd0, 0, 0, 0, 0, 2'd0, 8'd0);
    frame(FULL, 0, 2'd0, 0, 0, 0, 0, 2'd0, 8'd0);
    frame(FULL, 0, 2'd0, 0, 0, 0, 0, 2'd0, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
